// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI frame master (mode 0, MSB first).
package spi_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SHIFT,
        HOLD,
        GAP
    } spi_state_t;

    localparam int SPI_FRAME_BITS  = 16;
    localparam int SPI_HALF_PERIOD = 40;

    // Mode-0 polarities: sclk idles low, chip select is active low.
    localparam logic SCLK_IDLE = 1'b0;
    localparam logic CS_ACTIVE = 1'b0;

endpackage

// File: rtl/spi_half_tick.sv
// Half-period tick generator: one-cycle tick every HALF_PERIOD clk cycles,
// held at zero while clear is high.
module spi_half_tick #(
    parameter int HALF_PERIOD = 40
) (
    input  logic clk,
    input  logic n_rst,
    input  logic clear,
    output logic tick
);

    localparam int CW = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;
    localparam logic [CW-1:0] LAST = CW'(HALF_PERIOD - 1);

    logic [CW-1:0] count;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst)
            count <= '0;
        else if (clear || count == LAST)
            count <= '0;
        else
            count <= count + 1'b1;
    end

    assign tick = !clear && (count == LAST);

endmodule

// File: rtl/spi_frame_master.sv
// SPI mode-0 frame master: shifts one FRAME_BITS frame out on mosi and in on miso.
// Define SPI_MISO_SYNC_EN to pass miso through a 2-flop synchronizer.
module spi_frame_master
    import spi_pkg::*;
#(
    parameter int FRAME_BITS  = SPI_FRAME_BITS,
    parameter int HALF_PERIOD = SPI_HALF_PERIOD
) (
    input  logic                  clk,
    input  logic                  n_rst,
    input  logic                  start,
    input  logic [FRAME_BITS-1:0] tx_data,
    output logic                  busy,
    output logic                  done,
    output logic [FRAME_BITS-1:0] rx_data,
    output logic                  sclk,
    output logic                  cs_n,
    output logic                  mosi,
    input  logic                  miso
);

    localparam int BW = $clog2(FRAME_BITS + 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(FRAME_BITS - 1);

    spi_state_t state, state_next;

    logic                  tick;
    logic                  accept;
    logic                  rise_tick;
    logic                  sample_en;
    logic                  miso_bit;
    logic [FRAME_BITS-1:0] tx_shift, tx_shift_d;
    logic [FRAME_BITS-1:0] rx_shift;
    logic [BW-1:0]         bit_cnt, bit_cnt_d;
    logic                  busy_d, done_d, sclk_d, cs_n_d, mosi_d;
    logic [FRAME_BITS-1:0] rx_data_d;

    spi_half_tick #(
        .HALF_PERIOD(HALF_PERIOD)
    ) u_half_tick (
        .clk  (clk),
        .n_rst(n_rst),
        .clear(state == IDLE),
        .tick (tick)
    );

    // A start seen on the GAP-exit tick chains straight into the next frame,
    // so held-high start gives back-to-back frames with a one-half-period cs_n gap.
    assign accept    = start && ((state == IDLE) || (state == GAP && tick));
    assign rise_tick = tick && ((state == SETUP) || (state == SHIFT && !sclk));

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = SETUP;
            SETUP:   if (tick) state_next = SHIFT;
            SHIFT:   if (tick && sclk && bit_cnt == LAST_BIT) state_next = HOLD;
            HOLD:    if (tick) state_next = GAP;
            GAP:     if (tick) state_next = start ? SETUP : IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy_d     = busy;
        done_d     = 1'b0;
        sclk_d     = sclk;
        cs_n_d     = cs_n;
        mosi_d     = mosi;
        rx_data_d  = rx_data;
        tx_shift_d = tx_shift;
        bit_cnt_d  = bit_cnt;
        case (state)
            SETUP: if (tick) sclk_d = ~SCLK_IDLE;
            SHIFT: begin
                if (tick) begin
                    sclk_d = ~sclk;
                    if (sclk) begin
                        if (bit_cnt == LAST_BIT) begin
                            mosi_d    = 1'b0;
                            bit_cnt_d = '0;
                        end else begin
                            mosi_d     = tx_shift[FRAME_BITS-2];
                            tx_shift_d = {tx_shift[FRAME_BITS-2:0], 1'b0};
                            bit_cnt_d  = bit_cnt + 1'b1;
                        end
                    end
                end
            end
            HOLD: begin
                if (tick) begin
                    cs_n_d    = ~CS_ACTIVE;
                    rx_data_d = rx_shift;
                    done_d    = 1'b1;
                end
            end
            GAP:     if (tick) busy_d = 1'b0;
            default: ;
        endcase
        if (accept) begin
            tx_shift_d = tx_data;
            mosi_d     = tx_data[FRAME_BITS-1];
            cs_n_d     = CS_ACTIVE;
            busy_d     = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            busy     <= 1'b0;
            done     <= 1'b0;
            rx_data  <= '0;
            sclk     <= SCLK_IDLE;
            cs_n     <= ~CS_ACTIVE;
            mosi     <= 1'b0;
            tx_shift <= '0;
            bit_cnt  <= '0;
        end else begin
            busy     <= busy_d;
            done     <= done_d;
            rx_data  <= rx_data_d;
            sclk     <= sclk_d;
            cs_n     <= cs_n_d;
            mosi     <= mosi_d;
            tx_shift <= tx_shift_d;
            bit_cnt  <= bit_cnt_d;
        end
    end

`ifdef SPI_MISO_SYNC_EN
    // The sample strobe is delayed by the synchronizer depth so the captured bit
    // is the miso level present at the sclk rising edge.
    logic [1:0] miso_sync;
    logic [1:0] rise_dly;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            miso_sync <= '0;
            rise_dly  <= '0;
        end else begin
            miso_sync <= {miso_sync[0], miso};
            rise_dly  <= {rise_dly[0], rise_tick};
        end
    end

    assign sample_en = rise_dly[1];
    assign miso_bit  = miso_sync[1];
`else
    assign sample_en = rise_tick;
    assign miso_bit  = miso;
`endif

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst)
            rx_shift <= '0;
        else if (sample_en)
            rx_shift <= {rx_shift[FRAME_BITS-2:0], miso_bit};
    end

endmodule

// File: tb/tb_spi_frame_master.sv
// Self-checking bench for spi_frame_master: default 16-bit/HP=40 instance plus
// an 8-bit/HP=2 instance, with a receive-data scoreboard per instance.
module tb_spi_frame_master;

    localparam int DONE_OFF   = 1320;
    localparam int BUSY_OFF   = 1360;
    localparam int S_DONE_OFF = 34;
    localparam int S_BUSY_OFF = 36;

    typedef struct {
        logic [15:0] tx;
        logic        lb;
        logic        lvl;
        logic [15:0] exp_rx;
    } vec_t;

    logic        clk = 1'b0;
    logic        n_rst;
    logic        start;
    logic [15:0] tx_data;
    logic        busy, done, sclk, cs_n, mosi, miso;
    logic [15:0] rx_data;
    logic        loopback, miso_level;

    logic        s_start;
    logic [7:0]  s_tx;
    logic        s_busy, s_done, s_sclk, s_cs_n, s_mosi, s_miso;
    logic [7:0]  s_rx;

    int errors = 0;
    int checks = 0;

    logic [15:0] exp_q[$];
    logic [7:0]  s_exp_q[$];

    always #5 clk = ~clk;

    assign miso   = loopback ? mosi : miso_level;
    assign s_miso = s_mosi;

    spi_frame_master dut (
        .clk(clk), .n_rst(n_rst), .start(start), .tx_data(tx_data),
        .busy(busy), .done(done), .rx_data(rx_data), .sclk(sclk),
        .cs_n(cs_n), .mosi(mosi), .miso(miso)
    );

    spi_frame_master #(.FRAME_BITS(8), .HALF_PERIOD(2)) dut_small (
        .clk(clk), .n_rst(n_rst), .start(s_start), .tx_data(s_tx),
        .busy(s_busy), .done(s_done), .rx_data(s_rx), .sclk(s_sclk),
        .cs_n(s_cs_n), .mosi(s_mosi), .miso(s_miso)
    );

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // Monitor for the default instance: frame start is taken from the cs_n fall.
    int          cyc = 0;
    int          e0 = 0, rises = 0, rises_at_done = 0, dones = 0;
    int          done_off = 0, busy_off = 0, done_space = 0, last_done_cyc = 0;
    int          cs_rise_cyc = 0, cs_gap = 0;
    logic        prev_sclk = 1'b0, prev_busy = 1'b0, prev_cs_n = 1'b1, mosi_high = 1'b0;
    logic [15:0] mosi_cap = '0;

    always @(negedge clk) begin
        cyc       <= cyc + 1;
        prev_sclk <= sclk;
        prev_busy <= busy;
        prev_cs_n <= cs_n;
        if (n_rst) begin
            if (prev_cs_n && !cs_n) begin
                e0        <= cyc;
                rises     <= 0;
                mosi_high <= mosi;
                cs_gap    <= cyc - cs_rise_cyc;
            end else if (mosi) begin
                mosi_high <= 1'b1;
            end
            if (!prev_cs_n && cs_n) cs_rise_cyc <= cyc;
            if (!prev_sclk && sclk) begin
                rises    <= rises + 1;
                mosi_cap <= {mosi_cap[14:0], mosi};
            end
            if (done) begin
                dones         <= dones + 1;
                done_off      <= cyc - e0;
                done_space    <= cyc - last_done_cyc;
                last_done_cyc <= cyc;
                rises_at_done <= rises;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected done: rx_data=0x%0h with no frame outstanding", rx_data);
                end else begin
                    check_output("rx_data", {16'h0, rx_data}, {16'h0, exp_q.pop_front()});
                end
            end
            if (prev_busy && !busy) busy_off <= cyc - e0;
        end
    end

    // Monitor for the 8-bit instance.
    int   s_e0 = 0, s_dones = 0, s_done_off = 0, s_busy_off = 0;
    logic s_prev_cs_n = 1'b1, s_prev_busy = 1'b0;

    always @(negedge clk) begin
        s_prev_cs_n <= s_cs_n;
        s_prev_busy <= s_busy;
        if (n_rst) begin
            if (s_prev_cs_n && !s_cs_n) s_e0 <= cyc;
            if (s_done) begin
                s_dones    <= s_dones + 1;
                s_done_off <= cyc - s_e0;
                if (s_exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected small done: rx_data=0x%0h", s_rx);
                end else begin
                    check_output("small rx_data", {24'h0, s_rx}, {24'h0, s_exp_q.pop_front()});
                end
            end
            if (s_prev_busy && !s_busy) s_busy_off <= cyc - s_e0;
        end
    end

    task automatic wait_dones(input int target, input int budget);
        int n = 0;
        while (dones < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        if (dones < target) begin
            checks++;
            errors++;
            $display("[TB] FAIL done timeout: dones=%0d expected %0d", dones, target);
        end
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while (busy && n < budget) begin
            @(negedge clk);
            n++;
        end
        repeat (2) @(negedge clk);
        if (busy) begin
            checks++;
            errors++;
            $display("[TB] FAIL busy timeout: busy=%0b expected 0", busy);
        end
    endtask

    task automatic apply_stimulus(input logic [15:0] tx, input logic lb, input logic lvl, input logic [15:0] exp_rx);
        int d0 = dones;
        @(negedge clk);
        tx_data    = tx;
        loopback   = lb;
        miso_level = lvl;
        start      = 1'b1;
        exp_q.push_back(exp_rx);
        @(negedge clk);
        start   = 1'b0;
        tx_data = ~tx;
        wait_dones(d0 + 1, 2000);
        wait_idle(200);
    endtask

    vec_t vecs[4];

    initial begin
        int d0;
        logic [7:0] s_vals[2];

        vecs[0] = '{16'hA5C3, 1'b1, 1'b0, 16'hA5C3};
        vecs[1] = '{16'h0000, 1'b0, 1'b1, 16'hFFFF};
        vecs[2] = '{16'h0000, 1'b0, 1'b0, 16'h0000};
        vecs[3] = '{16'h3C96, 1'b1, 1'b0, 16'h3C96};
        s_vals[0] = 8'h5A;
        s_vals[1] = 8'h81;

        n_rst = 1'b0; start = 1'b0; tx_data = '0; loopback = 1'b1; miso_level = 1'b0;
        s_start = 1'b0; s_tx = '0;
        repeat (3) @(negedge clk);
        check_output("reset busy", busy, 0);
        check_output("reset done", done, 0);
        check_output("reset rx_data", rx_data, 0);
        check_output("reset sclk", sclk, 0);
        check_output("reset cs_n", cs_n, 1);
        check_output("reset mosi", mosi, 0);
        n_rst = 1'b1;
        repeat (2) @(negedge clk);

        // Small instance: 8-bit loopback frames at HP=2.
        for (int i = 0; i < 2; i++) begin
            d0 = s_dones;
            s_tx    = s_vals[i];
            s_start = 1'b1;
            s_exp_q.push_back(s_vals[i]);
            @(negedge clk);
            s_start = 1'b0;
            s_tx    = 8'hFF;
            for (int n = 0; n < 100 && s_dones == d0; n++) @(negedge clk);
            repeat (6) @(negedge clk);
            check_output("small done count", s_dones, d0 + 1);
            check_output("small done offset", s_done_off, S_DONE_OFF);
            check_output("small busy offset", s_busy_off, S_BUSY_OFF);
        end

        // Table-driven single frames on the default instance.
        for (int i = 0; i < 4; i++) begin
            apply_stimulus(vecs[i].tx, vecs[i].lb, vecs[i].lvl, vecs[i].exp_rx);
            check_output("done offset", done_off, DONE_OFF);
            check_output("busy offset", busy_off, BUSY_OFF);
            check_output("sclk rises", rises_at_done, 16);
            check_output("mosi frame", mosi_cap, vecs[i].tx);
            if (!vecs[i].lb) check_output("mosi stays low", mosi_high, 0);
        end

        // Start while busy is ignored and not queued.
        d0 = dones;
        @(negedge clk);
        tx_data = 16'hA5C3; loopback = 1'b1; start = 1'b1;
        exp_q.push_back(16'hA5C3);
        @(negedge clk);
        start = 1'b0;
        repeat (498) @(negedge clk);
        tx_data = 16'h1234; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_dones(d0 + 1, 2000);
        wait_idle(200);
        repeat (50) @(negedge clk);
        check_output("ignored start done count", dones, d0 + 1);
        check_output("ignored start mosi frame", mosi_cap, 16'hA5C3);
        check_output("ignored start busy idle", busy, 0);
        check_output("ignored start cs_n idle", cs_n, 1);

        // Reset mid-frame aborts immediately with no done.
        @(negedge clk);
        tx_data = 16'h0F0F; loopback = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (598) @(negedge clk);
        d0 = dones;
        #2 n_rst = 1'b0;
        #1;
        check_output("abort cs_n", cs_n, 1);
        check_output("abort sclk", sclk, 0);
        check_output("abort busy", busy, 0);
        check_output("abort done", done, 0);
        repeat (3) @(negedge clk);
        check_output("abort rx_data", rx_data, 0);
        n_rst = 1'b1;
        repeat (1500) @(negedge clk);
        check_output("abort no done", dones, d0);
        apply_stimulus(16'hA5C3, 1'b1, 1'b0, 16'hA5C3);
        check_output("post-abort done offset", done_off, DONE_OFF);
        check_output("post-abort sclk rises", rises_at_done, 16);

        // start held high: three chained frames.
        d0 = dones;
        @(negedge clk);
        tx_data = 16'hA5C3; loopback = 1'b1; start = 1'b1;
        repeat (3) exp_q.push_back(16'hA5C3);
        wait_dones(d0 + 2, 3000);
        check_output("chain done spacing 1", done_space, BUSY_OFF);
        check_output("chain cs_n gap 1", cs_gap, 40);
        wait_dones(d0 + 3, 2000);
        start = 1'b0;
        check_output("chain done spacing 2", done_space, BUSY_OFF);
        check_output("chain cs_n gap 2", cs_gap, 40);
        wait_idle(200);
        check_output("chain scoreboard drained", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
